// File: rtl/zeroriscy_register_file_sb_if.sv
// ---------------------------------------------------------------------------
// zeroriscy_register_file_sb_if
// Bus bundle between the ID stage and the scoreboarded register file.
//   raddr_i        : read addresses, port k in bits [5k+4:5k]
//   rdata_o        : read data, port k in slice k
//   rbusy_o        : per read port, addressed register has a pending write
//   waddr/wdata/we : write port A (ALU) and write port B (LSU/multdiv)
//   rsv_addr_i/rsv_i : reserve a destination register (mark pending)
//   wr_collision_o : registered pulse, A and B hit the same register
//   busy_any_o     : OR of all busy bits
// master = ID-stage side, slave = register file.
// ---------------------------------------------------------------------------
interface zeroriscy_register_file_sb_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2
);
  logic [5*NUM_RD_PORTS-1:0]          raddr_i;
  logic [DATA_WIDTH*NUM_RD_PORTS-1:0] rdata_o;
  logic [NUM_RD_PORTS-1:0]            rbusy_o;
  logic [4:0]                         waddr_a_i;
  logic [DATA_WIDTH-1:0]              wdata_a_i;
  logic                               we_a_i;
  logic [4:0]                         waddr_b_i;
  logic [DATA_WIDTH-1:0]              wdata_b_i;
  logic                               we_b_i;
  logic [4:0]                         rsv_addr_i;
  logic                               rsv_i;
  logic                               wr_collision_o;
  logic                               busy_any_o;

  modport master (
    output raddr_i, waddr_a_i, wdata_a_i, we_a_i,
    output waddr_b_i, wdata_b_i, we_b_i, rsv_addr_i, rsv_i,
    input  rdata_o, rbusy_o, wr_collision_o, busy_any_o
  );

  modport slave (
    input  raddr_i, waddr_a_i, wdata_a_i, we_a_i,
    input  waddr_b_i, wdata_b_i, we_b_i, rsv_addr_i, rsv_i,
    output rdata_o, rbusy_o, wr_collision_o, busy_any_o
  );
endinterface

// File: rtl/zeroriscy_register_file_sb.sv
// ---------------------------------------------------------------------------
// zeroriscy_register_file_sb
// Flip-flop register file with NUM_RD_PORTS combinational read ports, two
// write ports (A: ALU, B: LSU/multdiv) and a per-register pending-write
// scoreboard. The decoder reserves a destination (rsv_i); a port-B write
// releases it. Optional same-cycle write-to-read bypass.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   test_en_i : test enable, no functional effect
//   rf        : bus bundle (slave modport), see zeroriscy_register_file_sb_if
// ---------------------------------------------------------------------------
module zeroriscy_register_file_sb #(
  parameter int RV32E        = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int BYPASS_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          test_en_i,
  zeroriscy_register_file_sb_if.slave   rf
);

  localparam int NUM_WORDS = (RV32E != 0) ? 16 : 32;
  localparam int AW        = (RV32E != 0) ? 4 : 5;

  // x0 and (under RV32E) addresses with bit 4 set are not real registers.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && !((RV32E != 0) && a[4]);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
  logic [NUM_WORDS-1:0]  busy_q, busy_d;
  logic                  coll_q, coll_d;
  logic                  wa_ok, wb_ok, rsv_ok;

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  always_comb begin
    wa_ok  = rf.we_a_i && addr_ok(rf.waddr_a_i);
    wb_ok  = rf.we_b_i && addr_ok(rf.waddr_b_i);
    rsv_ok = rf.rsv_i  && addr_ok(rf.rsv_addr_i);
    coll_d = wa_ok && wb_ok && (rf.waddr_a_i == rf.waddr_b_i);

    for (int i = 0; i < NUM_WORDS; i++) begin
      mem_d[i] = mem_q[i];
    end
    busy_d = busy_q;

    // Port B is applied last so it wins a same-address collision.
    if (wa_ok) mem_d[rf.waddr_a_i[AW-1:0]] = rf.wdata_a_i;
    if (wb_ok) begin
      mem_d[rf.waddr_b_i[AW-1:0]]  = rf.wdata_b_i;
      busy_d[rf.waddr_b_i[AW-1:0]] = 1'b0;
    end
    // Reserve after release: a back-to-back long-latency op keeps the bit set.
    if (rsv_ok) busy_d[rf.rsv_addr_i[AW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      coll_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
      coll_q <= coll_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      logic [4:0]            ra;
      logic [DATA_WIDTH-1:0] rd;
      logic                  rb;

      assign ra = rf.raddr_i[5*gi +: 5];

      always_comb begin
        rd = '0;
        rb = 1'b0;
        if (addr_ok(ra)) begin
          rd = mem_q[ra[AW-1:0]];
          rb = busy_q[ra[AW-1:0]];
          if (BYPASS_EN != 0) begin
            // A port-B hit is the pending write landing, so the register is
            // no longer busy from the reader's point of view.
            if (wb_ok && (rf.waddr_b_i == ra)) begin
              rd = rf.wdata_b_i;
              rb = 1'b0;
            end else if (wa_ok && (rf.waddr_a_i == ra)) begin
              rd = rf.wdata_a_i;
            end
          end
        end
      end

      assign rf.rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
      assign rf.rbusy_o[gi] = rb;
    end
  endgenerate

  assign rf.wr_collision_o = coll_q;
  assign rf.busy_any_o     = |busy_q;

endmodule

// File: doc/zeroriscy_register_file_sb.md
Name: zeroriscy_register_file_sb

Overview:
- Parametrised flip-flop register file for zero-riscy. Next generation of the single-write-port FF register file.
- Adds a configurable number of read ports and a second write port for long-latency results (LSU/multdiv).
- Adds a per-register pending-write scoreboard and optional write-to-read bypass.
- Sits in the ID stage. The decoder reserves a destination register; the LSU/multdiv write-back releases it.

Parameters:
- RV32E, 0, 1 selects 16 architectural registers; 0 selects 32.
- DATA_WIDTH, 32, register width in bits.
- NUM_RD_PORTS, 2, number of read ports (legal values 2..3).
- BYPASS_EN, 1, 1 means same-cycle write data is forwarded to the read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- test_en_i  in  1  test enable; no functional effect.
- raddr_i  in  5*NUM_RD_PORTS  read addresses; port k uses bits [5k+4:5k].
- rdata_o  out  DATA_WIDTH*NUM_RD_PORTS  read data, port k in slice k.
- rbusy_o  out  NUM_RD_PORTS  1 means the addressed register has a pending long-latency write.
- waddr_a_i  in  5  write port A (ALU) address.
- wdata_a_i  in  DATA_WIDTH  write port A data.
- we_a_i  in  1  write port A enable.
- waddr_b_i  in  5  write port B (LSU/multdiv) address.
- wdata_b_i  in  DATA_WIDTH  write port B data.
- we_b_i  in  1  write port B enable; also clears the busy bit for waddr_b_i.
- rsv_addr_i  in  5  address to mark pending.
- rsv_i  in  1  reserve strobe.
- wr_collision_o  out  1  registered pulse: A and B wrote the same register in the previous cycle.
- busy_any_o  out  1  OR of all busy bits (registered state).

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers 0;
  - all busy bits 0;
  - wr_collision_o = 0.
  - Reset asserted mid-operation discards pending reservations and in-flight writes immediately.
- Address space:
  - NUM_WORDS = 16 if RV32E, else 32.
  - Out-of-range addresses are those with bit4 set when RV32E=1.
  - Writes and reserves to an out-of-range address are dropped.
  - Reads of an out-of-range address return 0 with busy 0.
- x0:
  - reads always return 0 with rbusy 0, including under bypass;
  - writes and reserves to x0 are dropped.
- Writes: registered on the rising clk edge. Latency 1 without bypass.
- Write collision (we_a_i and we_b_i, same valid nonzero address):
  - port B data is stored;
  - wr_collision_o = 1 in the following cycle, for one cycle only.
  - No collision pulse for x0 or out-of-range addresses.
- Reads: combinational from registered state.
- BYPASS_EN=1:
  - if a read address matches an active, valid, nonzero write address this cycle, rdata returns the write data;
  - if both ports match, B takes precedence over A;
  - rbusy for that port is 0 when port B matches.
- BYPASS_EN=0: reads return the pre-edge contents; rbusy returns the registered busy bit.
- Scoreboard, next state per register i:
  - busy_i' = (rsv_i & rsv_addr_i==i) | (busy_i & ~(we_b_i & waddr_b_i==i)).
  - Reserve and release of the same register in the same cycle: reserve wins, so busy stays 1 (back-to-back long-latency ops).
  - Port A writes never change busy bits.
  - Reserving an already-busy register: stays 1, no error.
  - Release of a non-busy register: data written, busy stays 0.
- busy_any_o: from the busy register state only; unaffected by bypass.

Test Plan:
1. Reset, then read all addresses on all ports -> rdata 0, rbusy 0, busy_any_o 0. Assert rst_n low mid-reservation -> busy cleared within the same cycle, before the next edge.
2. we_a_i, addr 5, data 0xDEADBEEF; same cycle, read port 0 addr 5:
   - BYPASS_EN=1 -> 0xDEADBEEF in the same cycle.
   - BYPASS_EN=0 -> 0 that cycle, 0xDEADBEEF the next.
   - Repeat with addr 0 -> always 0.
3. Same cycle: we_a_i addr 7 data 0x1111, we_b_i addr 7 data 0x2222 -> reg7 = 0x2222; wr_collision_o = 1 for exactly one cycle after the edge. Repeat with addr 0 -> no pulse.
4. rsv_i addr 9; then port-A write to 9 -> rbusy for 9 stays 1; then we_b_i to 9 data 0xA5 -> rbusy clears (same cycle under bypass); busy_any_o falls after the edge.
5. Busy reg 9: assert rsv_i addr 9 and we_b_i addr 9 in the same cycle -> data updated, busy remains 1.
6. RV32E=1, NUM_RD_PORTS=3: write and reserve addr 17 -> dropped; reads of 17 give 0 with rbusy 0. The three ports read addrs 1,2,15 concurrently -> correct, independent data on each port.
